// File: rtl/generic_conv_task_scheduler.sv
// Convolution task sequencer: walks kernel sets and output rows, issuing
// kernel-set load and row compute commands over valid/ready handshakes.
module generic_conv_task_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] kernal_set_n,
    input  logic [15:0] ofmap_h,
    input  logic [2:0]  conv_vertical_stride,
    input  logic [4:0]  kernal_h_dilated,
    output logic        busy,
    output logic        done,
    output logic        kset_cmd_valid,
    input  logic        kset_cmd_ready,
    output logic [15:0] kset_cmd_id,
    output logic        row_cmd_valid,
    input  logic        row_cmd_ready,
    output logic [15:0] row_cmd_ofrow,
    output logic [15:0] row_cmd_ifrow,
    output logic [4:0]  row_cmd_vspan,
    output logic        row_cmd_last,
    input  logic        row_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_KSET,
        S_ROW_REQ,
        S_ROW_WAIT,
        S_KSET_NEXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] kset_n_q, kset_n_d;
    logic [15:0] ofmap_h_q, ofmap_h_d;
    logic [2:0]  stride_q, stride_d;
    logic [4:0]  vspan_q, vspan_d;
    logic [15:0] kset_id_q, kset_id_d;
    logic [15:0] ofrow_q, ofrow_d;
    logic [15:0] ifrow_q, ifrow_d;
    logic [15:0] ifrow_step;

    // Input-row advance per output row; accumulated rather than multiplied.
    assign ifrow_step = {13'd0, stride_q} + 16'd1;

    always_comb begin
        state_d   = state_q;
        kset_n_d  = kset_n_q;
        ofmap_h_d = ofmap_h_q;
        stride_d  = stride_q;
        vspan_d   = vspan_q;
        kset_id_d = kset_id_q;
        ofrow_d   = ofrow_q;
        ifrow_d   = ifrow_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    kset_n_d  = kernal_set_n;
                    ofmap_h_d = ofmap_h;
                    stride_d  = conv_vertical_stride;
                    vspan_d   = kernal_h_dilated;
                    kset_id_d = 16'd0;
                    ofrow_d   = 16'd0;
                    ifrow_d   = 16'd0;
                    state_d   = S_LD_KSET;
                end
            end
            S_LD_KSET: begin
                if (kset_cmd_ready) state_d = S_ROW_REQ;
            end
            S_ROW_REQ: begin
                if (row_cmd_ready) state_d = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                if (row_done) begin
                    if (ofrow_q == ofmap_h_q) begin
                        state_d = S_KSET_NEXT;
                    end else begin
                        ofrow_d = ofrow_q + 16'd1;
                        ifrow_d = ifrow_q + ifrow_step;
                        state_d = S_ROW_REQ;
                    end
                end
            end
            S_KSET_NEXT: begin
                if (kset_id_q == kset_n_q) begin
                    state_d = S_DONE;
                end else begin
                    kset_id_d = kset_id_q + 16'd1;
                    ofrow_d   = 16'd0;
                    ifrow_d   = 16'd0;
                    state_d   = S_LD_KSET;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kset_n_q  <= 16'd0;
            ofmap_h_q <= 16'd0;
            stride_q  <= 3'd0;
            vspan_q   <= 5'd0;
            kset_id_q <= 16'd0;
            ofrow_q   <= 16'd0;
            ifrow_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            kset_n_q  <= kset_n_d;
            ofmap_h_q <= ofmap_h_d;
            stride_q  <= stride_d;
            vspan_q   <= vspan_d;
            kset_id_q <= kset_id_d;
            ofrow_q   <= ofrow_d;
            ifrow_q   <= ifrow_d;
        end
    end

    // Everything below decodes registered state only, so valids never see ready/row_done.
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign kset_cmd_valid = (state_q == S_LD_KSET);
    assign row_cmd_valid  = (state_q == S_ROW_REQ);
    assign kset_cmd_id    = kset_id_q;
    assign row_cmd_ofrow  = ofrow_q;
    assign row_cmd_ifrow  = ifrow_q;
    assign row_cmd_vspan  = vspan_q;
    // Gated by busy so the cleared config (0 == 0) does not flag last while idle.
    assign row_cmd_last   = busy && (ofrow_q == ofmap_h_q) && (kset_id_q == kset_n_q);

endmodule

// File: tb/tb_generic_conv_task_scheduler.sv
// Scoreboard bench for generic_conv_task_scheduler: directed tasks push
// expected commands; a monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_generic_conv_task_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] kernal_set_n;
    logic [15:0] ofmap_h;
    logic [2:0]  conv_vertical_stride;
    logic [4:0]  kernal_h_dilated;
    logic        busy;
    logic        done;
    logic        kset_cmd_valid;
    logic        kset_cmd_ready;
    logic [15:0] kset_cmd_id;
    logic        row_cmd_valid;
    logic        row_cmd_ready;
    logic [15:0] row_cmd_ofrow;
    logic [15:0] row_cmd_ifrow;
    logic [4:0]  row_cmd_vspan;
    logic        row_cmd_last;
    logic        row_done;
    logic        dp_done;
    logic        spur_done;

    always #5 clk = ~clk;
    assign row_done = dp_done | spur_done;

    generic_conv_task_scheduler dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .kernal_set_n         (kernal_set_n),
        .ofmap_h              (ofmap_h),
        .conv_vertical_stride (conv_vertical_stride),
        .kernal_h_dilated     (kernal_h_dilated),
        .busy                 (busy),
        .done                 (done),
        .kset_cmd_valid       (kset_cmd_valid),
        .kset_cmd_ready       (kset_cmd_ready),
        .kset_cmd_id          (kset_cmd_id),
        .row_cmd_valid        (row_cmd_valid),
        .row_cmd_ready        (row_cmd_ready),
        .row_cmd_ofrow        (row_cmd_ofrow),
        .row_cmd_ifrow        (row_cmd_ifrow),
        .row_cmd_vspan        (row_cmd_vspan),
        .row_cmd_last         (row_cmd_last),
        .row_done             (row_done)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  v;
        logic        last;
    } exp_t;

    localparam logic [1:0] K_KSET = 2'd0;
    localparam logic [1:0] K_ROW  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   dp_delay  = 3;
    int   dp_limit  = 1000000;
    bit   bp_en     = 1'b0;
    bit   noise_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic take(input string what, output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = '0;
        if (ok) begin
            e = exp_q.pop_front();
        end else begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: got a %s transaction, required none", what, what);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] v, input logic l);
        exp_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        e.v    = v;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Expected sequence written from the row formula ifrow = ofrow*(stride+1) mod 2^16.
    task automatic push_task(input int ksn, input int oh, input int s, input int vs,
                             input int max_rows, input bit with_done);
        logic [31:0] prod;
        for (int k = 0; k <= ksn; k++) begin
            push_exp(K_KSET, 16'(k), 16'd0, 5'd0, 1'b0);
            for (int r = 0; r <= oh && r < max_rows; r++) begin
                prod = 32'(r * (s + 1));
                push_exp(K_ROW, 16'(r), prod[15:0], 5'(vs), (r == oh) && (k == ksn));
            end
        end
        if (with_done) push_exp(K_DONE, 16'd0, 16'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample at negedge, where DUT outputs and bench inputs are settled.
    initial begin : monitor
        int   cyc;
        int   fin_cyc;
        bit   last_pend;
        bit   ok;
        exp_t e;
        bit   pk_v, pk_r, pr_v, pr_r, p_rst;
        logic [15:0] pk_id, pr_of, pr_if;
        logic [4:0]  pr_vs;
        logic        pr_last;
        cyc = 0; fin_cyc = -100; last_pend = 1'b0;
        pk_v = 0; pk_r = 0; pr_v = 0; pr_r = 0; p_rst = 0;
        pk_id = 0; pr_of = 0; pr_if = 0; pr_vs = 0; pr_last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) last_pend = 1'b0;
            if (p_rst && pk_v && !pk_r) begin
                chk("kset_hold_valid", 32'(kset_cmd_valid), 32'd1);
                chk("kset_hold_id", 32'(kset_cmd_id), 32'(pk_id));
            end
            if (p_rst && pr_v && !pr_r) begin
                chk("row_hold_valid", 32'(row_cmd_valid), 32'd1);
                chk("row_hold_ofrow", 32'(row_cmd_ofrow), 32'(pr_of));
                chk("row_hold_ifrow", 32'(row_cmd_ifrow), 32'(pr_if));
                chk("row_hold_vspan", 32'(row_cmd_vspan), 32'(pr_vs));
                chk("row_hold_last", 32'(row_cmd_last), 32'(pr_last));
            end
            if (rst_n && last_pend && row_done) begin
                fin_cyc   = cyc;
                last_pend = 1'b0;
            end
            if (rst_n && kset_cmd_valid && kset_cmd_ready) begin
                $display("txn kset id=%0d", kset_cmd_id);
                take("kset", e, ok);
                if (ok) begin
                    chk("kset_kind", 32'(K_KSET), 32'(e.kind));
                    chk("kset_id", 32'(kset_cmd_id), 32'(e.a));
                end
            end
            if (rst_n && row_cmd_valid && row_cmd_ready) begin
                $display("txn row ofrow=%0d ifrow=%0d vspan=%0d last=%0b",
                         row_cmd_ofrow, row_cmd_ifrow, row_cmd_vspan, row_cmd_last);
                take("row", e, ok);
                if (ok) begin
                    chk("row_kind", 32'(K_ROW), 32'(e.kind));
                    chk("row_ofrow", 32'(row_cmd_ofrow), 32'(e.a));
                    chk("row_ifrow", 32'(row_cmd_ifrow), 32'(e.b));
                    chk("row_vspan", 32'(row_cmd_vspan), 32'(e.v));
                    chk("row_last", 32'(row_cmd_last), 32'(e.last));
                end
                if (row_cmd_last) last_pend = 1'b1;
            end
            if (done) begin
                $display("txn done cycles_after_last_row_done=%0d", cyc - fin_cyc);
                take("done", e, ok);
                if (ok) chk("done_kind", 32'(K_DONE), 32'(e.kind));
                chk("done_latency", 32'(cyc - fin_cyc), 32'd2);
                fin_cyc = -100;
            end
            pk_v = kset_cmd_valid; pk_r = kset_cmd_ready; pk_id = kset_cmd_id;
            pr_v = row_cmd_valid;  pr_r = row_cmd_ready;
            pr_of = row_cmd_ofrow; pr_if = row_cmd_ifrow; pr_vs = row_cmd_vspan; pr_last = row_cmd_last;
            p_rst = rst_n;
        end
    end

    // Datapath and ready model: row_done dp_delay cycles after each row handshake.
    initial begin : env
        int cnt, kh, rh, nhs;
        bit hs, rs;
        cnt = 0; kh = 0; rh = 0; nhs = 0;
        dp_done = 1'b0;
        kset_cmd_ready = 1'b1;
        row_cmd_ready  = 1'b1;
        forever begin
            @(negedge clk);
            hs = row_cmd_valid && row_cmd_ready && rst_n;
            rs = rst_n;
            @(posedge clk);
            #1;
            dp_done = 1'b0;
            if (!rs) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) dp_done = 1'b1;
                end
                if (hs) begin
                    if (nhs < dp_limit) begin
                        if (dp_delay <= 1) dp_done = 1'b1;
                        else cnt = dp_delay - 1;
                    end
                    nhs++;
                end
            end
            if (!busy) nhs = 0;
            if (!bp_en) begin
                kset_cmd_ready = 1'b1; row_cmd_ready = 1'b1; kh = 0; rh = 0;
            end else begin
                if (kset_cmd_valid) begin
                    if (kh < 5) begin kset_cmd_ready = 1'b0; kh++; end
                    else kset_cmd_ready = 1'b1;
                end else begin
                    kh = 0; kset_cmd_ready = 1'b0;
                end
                if (row_cmd_valid) begin
                    if (rh < 5) begin row_cmd_ready = 1'b0; rh++; end
                    else row_cmd_ready = 1'b1;
                end else begin
                    rh = 0; row_cmd_ready = 1'b0;
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_kset_valid"}, 32'(kset_cmd_valid), 32'd0);
        chk({tag, "_row_valid"}, 32'(row_cmd_valid), 32'd0);
        chk({tag, "_row_last"}, 32'(row_cmd_last), 32'd0);
        chk({tag, "_kset_id"}, 32'(kset_cmd_id), 32'd0);
        chk({tag, "_ofrow"}, 32'(row_cmd_ofrow), 32'd0);
        chk({tag, "_ifrow"}, 32'(row_cmd_ifrow), 32'd0);
        chk({tag, "_vspan"}, 32'(row_cmd_vspan), 32'd0);
    endtask

    task automatic start_task(input int ksn, input int oh, input int s, input int vs);
        kernal_set_n         = 16'(ksn);
        ofmap_h              = 16'(oh);
        conv_vertical_stride = 3'(s);
        kernal_h_dilated     = 5'(vs);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_to_kset_valid", 32'(kset_cmd_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            start     = noise_en && busy;
            spur_done = noise_en && (kset_cmd_valid || row_cmd_valid);
            if (noise_en && busy) begin
                kernal_set_n         = 16'($urandom);
                ofmap_h              = 16'($urandom);
                conv_vertical_stride = 3'($urandom);
                kernal_h_dilated     = 5'($urandom);
            end
            if (done) seen = 1'b1;
        end
        start     = 1'b0;
        spur_done = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done within %0d cycles, required done", tag, budget);
        end
        tick();
        chk({tag, "_idle_after_done"}, 32'(busy), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit hit;
        rst_n = 1'b0; start = 1'b0; spur_done = 1'b0;
        kernal_set_n = 16'd0; ofmap_h = 16'd0; conv_vertical_stride = 3'd0; kernal_h_dilated = 5'd0;
        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("post_reset");

        // Single kernel set, three rows, unit stride.
        dp_delay = 3;
        push_task(0, 2, 0, 4, 65536, 1'b1);
        start_task(0, 2, 0, 4);
        wait_done("t1", 200);

        // Two kernel sets, stride 2.
        dp_delay = 1;
        push_task(1, 1, 1, 2, 65536, 1'b1);
        start_task(1, 1, 1, 2);
        wait_done("t2", 200);

        // Same task with ready backpressure.
        bp_en    = 1'b1;
        dp_delay = 2;
        push_task(1, 1, 1, 2, 65536, 1'b1);
        start_task(1, 1, 1, 2);
        wait_done("t3_bp", 400);
        bp_en = 1'b0;
        tick();

        // Spurious row_done, start and config noise while busy.
        dp_delay = 3;
        noise_en = 1'b1;
        push_task(0, 2, 0, 4, 65536, 1'b1);
        start_task(0, 2, 0, 4);
        wait_done("t4_noise", 200);
        noise_en = 1'b0;

        // Reset while waiting on the second row, then replay.
        push_task(0, 2, 0, 4, 2, 1'b0);
        start_task(0, 2, 0, 4);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (busy && !row_cmd_valid && !kset_cmd_valid && row_cmd_ofrow == 16'd1) hit = 1'b1;
            else tick();
        end
        chk("t5_reached_row1_wait", 32'(hit), 32'd1);
        rst_n = 1'b0;
        tick();
        check_idle("t5_mid_reset");
        rst_n = 1'b1;
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) tick();
        check_idle("t5_idle_hold");
        push_task(0, 2, 0, 4, 65536, 1'b1);
        start_task(0, 2, 0, 4);
        wait_done("t5_replay", 200);

        // ifrow wrap: stride 8, row 8192 lands on ifrow 0; datapath stalls after row 8192.
        dp_delay = 1;
        dp_limit = 8193;
        push_task(0, 65535, 7, 31, 8194, 1'b0);
        start_task(0, 65535, 7, 31);
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            tick();
            if (exp_q.size() == 0) hit = 1'b1;
        end
        chk("t6_rows_drained", 32'(hit), 32'd1);
        repeat (5) tick();
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_stall_ofrow", 32'(row_cmd_ofrow), 32'd8193);
        chk("t6_stall_ifrow", 32'(row_cmd_ifrow), 32'd8);
        chk("t6_stall_last", 32'(row_cmd_last), 32'd0);
        rst_n = 1'b0;
        tick();
        check_idle("t6_reset");
        rst_n = 1'b1;
        dp_limit = 1000000;
        repeat (3) tick();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
